// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16-bit unsigned multiply (shift-add) / divide (restoring)
// with a two-word write-back to an 8x16 register file.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [2:0]  dest,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [2:0]  wbDest,
    output logic [15:0] wbData,
    output logic        wbWe,
    output logic        wbHb,
    output logic        wbLb
);

    localparam int unsigned W  = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_op, w_op_nxt;
    logic [RW-1:0]   r_dest, w_dest_nxt;
    logic [W-1:0]    r_opnd, w_opnd_nxt;   // multiplicand (MULU) or divisor (DIVU)
    logic [W-1:0]    r_hi, w_hi_nxt;       // product high / partial remainder
    logic [W-1:0]    r_lo, w_lo_nxt;       // product low / quotient
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            r_busy, r_done, r_we;
    logic [RW-1:0]   r_wb_dest;
    logic [W-1:0]    r_wb_data;
    logic            w_busy_nxt, w_done_nxt, w_we_nxt;
    logic [RW-1:0]   w_wb_dest_nxt;
    logic [W-1:0]    w_wb_data_nxt;

    logic [W:0]      w_mul_sum;
    logic [W:0]      w_div_t;
    logic            w_div_ge;
    logic [W-1:0]    w_div_r;

    // One iteration of each algorithm; the divisor compare is 17-bit so a
    // zero divisor always subtracts and fills the quotient with ones.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_div_t   = {r_hi, r_lo[W-1]};
        w_div_ge  = (w_div_t >= {1'b0, r_opnd});
        w_div_r   = w_div_ge ? W'(w_div_t - {1'b0, r_opnd}) : w_div_t[W-1:0];
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_dest_nxt  = r_dest;
        w_opnd_nxt  = r_opnd;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_op_nxt    = op;
                    w_dest_nxt  = dest;
                    w_opnd_nxt  = op ? opB : opA;
                    w_hi_nxt    = '0;
                    w_lo_nxt    = op ? opA : opB;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_op) begin
                    w_hi_nxt = w_div_r;
                    w_lo_nxt = {r_lo[W-2:0], w_div_ge};
                end else begin
                    w_hi_nxt = w_mul_sum[W:1];
                    w_lo_nxt = {w_mul_sum[0], r_lo[W-1:1]};
                end
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_WB_LO;
                end
            end
            S_WB_LO: begin
                w_state_nxt = S_WB_HI;
            end
            S_WB_HI: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_we_nxt      = (w_state_nxt == S_WB_LO) || (w_state_nxt == S_WB_HI);
        w_done_nxt    = (w_state_nxt == S_WB_HI);
        w_wb_dest_nxt = '0;
        w_wb_data_nxt = '0;
        if (w_state_nxt == S_WB_LO) begin
            w_wb_dest_nxt = w_dest_nxt;
            w_wb_data_nxt = w_lo_nxt;
        end else if (w_state_nxt == S_WB_HI) begin
            w_wb_dest_nxt = w_dest_nxt + RW'(1);
            w_wb_data_nxt = w_hi_nxt;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_dest    <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_we      <= 1'b0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_dest    <= w_dest_nxt;
            r_opnd    <= w_opnd_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_we      <= w_we_nxt;
            r_wb_dest <= w_wb_dest_nxt;
            r_wb_data <= w_wb_data_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wbWe   = r_we;
    assign wbHb   = r_we;
    assign wbLb   = r_we;
    assign wbDest = r_wb_dest;
    assign wbData = r_wb_data;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit unsigned multiply/divide unit. It sits directly downstream of the 8×16-bit register file read ports and directly upstream of its write port. It takes the two read operands, computes for 16 cycles, then writes a 32-bit result back as two consecutive 16-bit register writes. Its write-back outputs connect one-to-one to the register file's `regDest`/`dataIn`/`we`/`hb`/`lb` inputs.

## Interface
Parameters: none (width fixed at 16, register index fixed at 3 bits).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only while `busy`=0.
- `op` in 1: 0 = MULU, 1 = DIVU.
- `dest` in 3: first destination register index.
- `opA` in 16: multiplicand / dividend (from register file `dataA`).
- `opB` in 16: multiplier / divisor (from register file `dataB`).
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle pulse during the final write-back cycle.
- `wbDest` out 3: write-back register index.
- `wbData` out 16: write-back data.
- `wbWe` out 1: write enable to the register file.
- `wbHb` out 1: high-byte enable; always equal to `wbWe`.
- `wbLb` out 1: low-byte enable; always equal to `wbWe`.

## Operation
- States: IDLE, RUN, WB_LO, WB_HI.
- IDLE:
  - If `start`=1 at an edge, latch `op`, `dest`, `opA`, `opB`, clear the 4-bit iteration counter, and go to RUN.
  - Later changes on `opA`/`opB`/`dest`/`op` have no effect.
- RUN: one iteration per edge. After the 16th iteration (counter 15), go to WB_LO.
- MULU (shift-add), 32-bit product register {hi,lo}:
  - Init: hi=0, lo=opB.
  - Each step: s = hi + (lo[0] ? opA : 0) as a 17-bit sum; {hi,lo} = {s,lo} >> 1.
  - Result: {hi,lo} = opA×opB, no overflow possible.
- DIVU (restoring), 17-bit remainder r, 16-bit quotient q:
  - Init: r=0, q=opA.
  - Each step: t = {r[15:0], q[15]}; if t ≥ opB then r = t − opB and shift 1 into q, else r = t and shift 0 into q.
  - Result: lo=q, hi=r[15:0].
  - Divide by zero is not special-cased. The algorithm must naturally yield q=0xFFFF, r=opA.
- WB_LO: drive `wbWe`=`wbHb`=`wbLb`=1, `wbDest`=dest, `wbData`=lo (product low / quotient). Next edge goes to WB_HI.
- WB_HI: drive write strobes =1, `wbDest`=(dest+1) mod 8 (7 wraps to 0), `wbData`=hi (product high / remainder), `done`=1. Next edge goes to IDLE.
- `busy`=1 in RUN, WB_LO and WB_HI; 0 in IDLE.
- When `wbWe`=0: `wbData`=0, `wbDest`=0, `wbHb`=`wbLb`=0.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

## Timing
- Reset: at any edge with `rst`=1, state goes to IDLE and datapath registers clear.
  - All outputs are 0 the following cycle.
  - `rst` overrides `start` on the same edge.
  - Reset mid-RUN or mid-WB aborts the operation; no further `wbWe` pulses occur.
- `start` is sampled at edge E0. RUN covers E1..E16.
- WB_LO holds during the cycle after E16; the register file commits the low word at E17.
- WB_HI holds during the cycle after E17; the register file commits the high word at E18, and `done` is high in that cycle.
- `busy` rises after E0 and falls after E18. Total: 18 edges from accept to IDLE.
- The earliest next accepted `start` is at E18+1, i.e. the first edge where `busy`=0 is seen.
- `start` while `busy`=1: ignored, with no queuing.
- dest=dest+1 collision does not arise, because the two writes are to distinct registers (mod-8 wrap).

## Test plan
- MULU opA=0x1234, opB=0x5678, dest=2 → write r2=0x0060 at E17, write r3=0x0626 at E18; `done` is high one cycle; `busy` is high for exactly 18 cycles.
- MULU 0xFFFF×0xFFFF, dest=7 → r7=0x0001, then r0=0xFFFE (wrap); `wbHb`=`wbLb`=`wbWe` on both writes.
- DIVU 0x03E8/0x0007, dest=4 → r4=0x008E, r5=0x0006. DIVU 0x1234/0x0000 → quotient 0xFFFF, remainder 0x1234.
- `start` pulsed with different operands at E5 and at E17 of an operation in flight → ignored; results match the original operands. `opA`/`opB` toggled during RUN → no effect on results.
- `rst` asserted at E8 of a MULU → next cycle all outputs are 0 and no `wbWe` ever asserts. A `start` at the first edge after reset deasserts is accepted and completes normally.
- `rst`=1 and `start`=1 on the same edge → stays IDLE, `busy`=0.
